// File: rtl/ddr5_cmd_scheduler_pkg.sv
// Shared types for the DDR5 command scheduler: command codes, FSM states, request record.
// Bank index everywhere is {bg, bank}.
package ddr5_cmd_scheduler_pkg;

  localparam int NUM_BANKS = 32;
  localparam logic [1:0] OP_WRITE = 2'd1;

  typedef enum logic [2:0] {
    PRE = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_PH1
  } sched_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  core;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } sched_req_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] t);
    return (t == 8'hFF) ? t : t + 8'd1;
  endfunction

endpackage

// File: rtl/ddr5_cmd_scheduler_fifo.sv
// Request FIFO; head visible the cycle after the push edge.
// push_rdy depends on occupancy only, so a full FIFO refuses a push even while popping.
module sched_req_fifo
  import ddr5_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  sched_req_t               push_dat,
  input  logic                     pop_vld,
  output sched_req_t               head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  sched_req_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign push_rdy = (count < FULL);
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_vld & (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (do_push && !do_pop)      count <= count + ONE;
      else if (!do_push && do_pop) count <= count - ONE;
    end
  end

endmodule

// File: rtl/ddr5_cmd_scheduler.sv
// FCFS DDR5 command scheduler: open-page bank table, per-bank and column timers, 2-cycle commands.
// Commands appear one cycle after the ARB decision; the FIFO stalls the front end via req_ready.
module ddr5_cmd_scheduler
  import ddr5_cmd_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int T_RCD       = 39,
  parameter int T_RP        = 39,
  parameter int T_RAS       = 76,
  parameter int T_CCD_L     = 12,
  parameter int T_CCD_S     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [3:0]                     req_core,
  input  logic [2:0]                     req_bg,
  input  logic [1:0]                     req_bank,
  input  logic [15:0]                    req_row,
  input  logic [9:0]                     req_col,
  output logic                           cmd_valid,
  output cmd_e                           cmd_code,
  output logic                           cmd_phase,
  output logic [2:0]                     cmd_bg,
  output logic [1:0]                     cmd_bank,
  output logic [15:0]                    cmd_row,
  output logic [9:0]                     cmd_col,
  output logic                           done_valid,
  output logic [3:0]                     done_core,
  output logic [1:0]                     done_op,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [7:0] RCD   = T_RCD[7:0];
  localparam logic [7:0] RP    = T_RP[7:0];
  localparam logic [7:0] RAS   = T_RAS[7:0];
  localparam logic [7:0] CCD_L = T_CCD_L[7:0];
  localparam logic [7:0] CCD_S = T_CCD_S[7:0];

  sched_req_t    req_dat;
  sched_req_t    head;
  logic          fifo_pop;
  sched_state_e  state;
  sched_state_e  state_nxt;
  logic          issue_vld;
  cmd_e          issue_code;

  logic [NUM_BANKS-1:0] bank_open;
  logic [15:0]          bank_row   [NUM_BANKS];
  logic [7:0]           bank_timer [NUM_BANKS];
  logic [7:0]           col_timer;
  logic [2:0]           last_col_bg;

  logic [4:0]  head_idx;
  logic [4:0]  cmd_idx;
  logic [7:0]  head_elapsed;
  logic [7:0]  col_elapsed;
  logic [7:0]  ccd_min;

  assign req_dat = '{op: req_op, core: req_core, bg: req_bg, bank: req_bank,
                     row: req_row, col: req_col};

  sched_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (req_valid),
    .push_rdy (req_ready),
    .push_dat (req_dat),
    .pop_vld  (fifo_pop),
    .head_dat (head),
    .count    (q_count)
  );

  assign head_idx = {head.bg, head.bank};
  assign cmd_idx  = {cmd_bg, cmd_bank};

  // Timers are judged by the value they will hold on the cycle the command appears.
  assign head_elapsed = sat_inc(bank_timer[head_idx]);
  assign col_elapsed  = sat_inc(col_timer);
  assign ccd_min      = (head.bg == last_col_bg) ? CCD_L : CCD_S;

  always_comb begin
    state_nxt  = state;
    issue_vld  = 1'b0;
    issue_code = PRE;
    fifo_pop   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (q_count != '0) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (q_count == '0) begin
          state_nxt = S_IDLE;
        end else if (!bank_open[head_idx]) begin
          if (head_elapsed >= RP) begin
            issue_vld  = 1'b1;
            issue_code = ACT;
            state_nxt  = S_PH1;
          end
        end else if (bank_row[head_idx] != head.row) begin
          if (head_elapsed >= RAS) begin
            issue_vld  = 1'b1;
            issue_code = PRE;
          end
        end else if (head_elapsed >= RCD && col_elapsed >= ccd_min) begin
          issue_vld  = 1'b1;
          issue_code = (head.op == OP_WRITE) ? WR : RD;
          state_nxt  = S_PH1;
        end
      end
      S_PH1: begin
        fifo_pop  = (cmd_code != ACT);
        state_nxt = (fifo_pop && q_count <= ONE) ? S_IDLE : S_ARB;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= PRE;
      cmd_phase  <= 1'b0;
      cmd_bg     <= '0;
      cmd_bank   <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      done_valid <= 1'b0;
      done_core  <= '0;
      done_op    <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      cmd_phase  <= 1'b0;
      done_valid <= 1'b0;
      if (issue_vld) begin
        cmd_valid <= 1'b1;
        cmd_code  <= issue_code;
        cmd_bg    <= head.bg;
        cmd_bank  <= head.bank;
        cmd_row   <= head.row;
        cmd_col   <= head.col;
      end else if (state == S_PH1) begin
        // Second cycle repeats the held command fields.
        cmd_valid <= 1'b1;
        cmd_phase <= 1'b1;
      end
      if (fifo_pop) begin
        done_valid <= 1'b1;
        done_core  <= head.core;
        done_op    <= head.op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open   <= '0;
      col_timer   <= 8'hFF;
      last_col_bg <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_timer[b] <= 8'hFF;
        bank_row[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (issue_vld && (issue_code == ACT || issue_code == PRE) && head_idx == 5'(b))
          bank_timer[b] <= '0;
        else
          bank_timer[b] <= sat_inc(bank_timer[b]);
      end
      if (issue_vld && issue_code == PRE) bank_open[head_idx] <= 1'b0;
      if (state == S_PH1 && cmd_code == ACT) begin
        bank_open[cmd_idx] <= 1'b1;
        bank_row[cmd_idx]  <= cmd_row;
      end
      if (issue_vld && (issue_code == RD || issue_code == WR)) begin
        col_timer   <= '0;
        last_col_bg <= head.bg;
      end else begin
        col_timer <= sat_inc(col_timer);
      end
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Scoreboard bench for ddr5_cmd_scheduler with short timing parameters.
// Retire order/data come from a push-time queue; command spacing from a ph0 command log.
module tb_ddr5_cmd_scheduler;
  import ddr5_cmd_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_core = '0;
  logic [2:0]  req_bg = '0;
  logic [1:0]  req_bank = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cmd_valid;
  cmd_e        cmd_code;
  logic        cmd_phase;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done_valid;
  logic [3:0]  done_core;
  logic [1:0]  done_op;
  logic [4:0]  q_count;

  ddr5_cmd_scheduler #(
    .QUEUE_DEPTH(16), .T_RCD(3), .T_RP(3), .T_RAS(6), .T_CCD_L(4), .T_CCD_S(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_core(req_core),
    .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_phase(cmd_phase), .cmd_bg(cmd_bg),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .done_valid(done_valid), .done_core(done_core), .done_op(done_op), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    cmd_e        code;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    int          cyc;
  } cmd_rec_t;

  cmd_rec_t    cmd_log[$];
  logic [5:0]  exp_q[$];
  int total = 0;
  int bad = 0;
  int last_push_cyc = 0;
  int stall_cycles = 0;
  bit full_watch = 0;
  int full_seen = 0;
  int full_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Command/done monitor, sampled on the falling edge.
  initial begin
    bit         ph1_due = 0;
    cmd_e       lc = PRE;
    logic [2:0] lbg = '0;
    logic [15:0] lrow = '0;
    logic [9:0] lcol = '0;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph1_due = 0;
      end else begin
        if (ph1_due) begin
          chk("ph1_vld", cmd_valid, 1);
          chk("ph1_phase", cmd_phase, 1);
          chk("ph1_code", cmd_code, lc);
          chk("ph1_bg", cmd_bg, lbg);
          chk("ph1_row", cmd_row, lrow);
          chk("ph1_col", cmd_col, lcol);
          ph1_due = 0;
        end else if (cmd_valid) begin
          chk("ph0_phase", cmd_phase, 0);
          cmd_log.push_back('{cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col, cyc});
          lc = cmd_code; lbg = cmd_bg; lrow = cmd_row; lcol = cmd_col;
          ph1_due = (cmd_code != PRE);
        end
        if (done_valid) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", done_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_core", done_core, e[5:2]);
            chk("done_op", done_op, e[1:0]);
          end
        end
        if (full_watch) begin
          if (q_count == 5'd16) full_seen++;
          if ((q_count == 5'd16) == req_ready) full_bad++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    req_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    cmd_log.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic push_req(input logic [1:0] op, input logic [3:0] core, input logic [2:0] bg,
                          input logic [1:0] bank, input logic [15:0] row, input logic [9:0] col);
    int w = 0;
    req_valid = 1; req_op = op; req_core = core; req_bg = bg;
    req_bank = bank; req_row = row; req_col = col;
    while (!req_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    stall_cycles += w;
    if (!req_ready) begin
      chk("push_timeout", req_ready, 1);
      req_valid = 0;
    end else begin
      @(posedge clk);
      #1;
      last_push_cyc = cyc;
      exp_q.push_back({core, op});
      @(negedge clk);
      req_valid = 0;
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1;
    @(negedge clk);

    // Closed-bank read
    do_reset();
    push_req(2'd0, 4'd3, 3'd2, 2'd1, 16'h00A5, 10'h010);
    chk("t1_q_count", q_count, 1);
    wait_drain();
    chk("t1_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() >= 2) begin
      chk("t1_act", cmd_log[0].code, ACT);
      chk("t1_act_row", cmd_log[0].row, 16'h00A5);
      chk("t1_act_bg", cmd_log[0].bg, 3'd2);
      chk("t1_act_bank", cmd_log[0].bank, 2'd1);
      chk("t1_latency", cmd_log[0].cyc - last_push_cyc, 2);
      chk("t1_rd", cmd_log[1].code, RD);
      chk("t1_rd_col", cmd_log[1].col, 10'h010);
      chk("t1_trcd", cmd_log[1].cyc - cmd_log[0].cyc, 3);
    end

    // Row hit, same bank group
    do_reset();
    push_req(2'd0, 4'd1, 3'd2, 2'd1, 16'h00A5, 10'h020);
    push_req(2'd0, 4'd2, 3'd2, 2'd1, 16'h00A5, 10'h030);
    wait_drain();
    chk("t2_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() >= 3) begin
      chk("t2_rd1", cmd_log[1].code, RD);
      chk("t2_rd2", cmd_log[2].code, RD);
      chk("t2_ccd_l", cmd_log[2].cyc - cmd_log[1].cyc, 4);
    end

    // Row hit on a different, already-open bank group
    do_reset();
    push_req(2'd2, 4'd4, 3'd5, 2'd0, 16'h0007, 10'h001);
    wait_drain();
    cmd_log.delete();
    push_req(2'd0, 4'd5, 3'd2, 2'd1, 16'h00A5, 10'h002);
    push_req(2'd0, 4'd6, 3'd5, 2'd0, 16'h0007, 10'h003);
    wait_drain();
    chk("t3_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() >= 3) begin
      chk("t3_rd2_code", cmd_log[2].code, RD);
      chk("t3_rd2_bg", cmd_log[2].bg, 3'd5);
      chk("t3_ccd_s", cmd_log[2].cyc - cmd_log[1].cyc, 2);
    end

    // Row conflict
    do_reset();
    push_req(2'd0, 4'd7, 3'd1, 2'd0, 16'h0005, 10'h000);
    push_req(2'd0, 4'd8, 3'd1, 2'd0, 16'h0009, 10'h004);
    wait_drain();
    chk("t4_ncmd", cmd_log.size(), 5);
    if (cmd_log.size() >= 5) begin
      chk("t4_pre", cmd_log[2].code, PRE);
      chk("t4_tras", (cmd_log[2].cyc - cmd_log[0].cyc) >= 6, 1);
      chk("t4_act2", cmd_log[3].code, ACT);
      chk("t4_act2_row", cmd_log[3].row, 16'h0009);
      chk("t4_trp", cmd_log[3].cyc - cmd_log[2].cyc, 3);
      chk("t4_rd2", cmd_log[4].code, RD);
      chk("t4_trcd", cmd_log[4].cyc - cmd_log[3].cyc, 3);
    end

    // Full FIFO: back-to-back conflicting requests, ops cycle through read/write/ifetch
    do_reset();
    stall_cycles = 0;
    full_seen = 0;
    full_bad = 0;
    full_watch = 1;
    for (int i = 0; i < 20; i++)
      push_req(2'(i % 3), 4'(i % 16), 3'd4, 2'd2, 16'(i), 10'(i));
    wait_drain();
    full_watch = 0;
    chk("t5_full_seen", full_seen > 0, 1);
    chk("t5_ready_vs_full", full_bad, 0);
    chk("t5_push_stalled", stall_cycles > 0, 1);
    n_rd = 0;
    foreach (cmd_log[k]) if (cmd_log[k].code == RD || cmd_log[k].code == WR) n_rd++;
    chk("t5_col_cmds", n_rd, 20);

    // Reset during ACT phase 1 with 5 queued
    do_reset();
    push_req(2'd0, 4'd10, 3'd3, 2'd2, 16'h0011, 10'h000);
    wait_drain();
    cmd_log.delete();
    for (int i = 0; i < 5; i++)
      push_req(2'd0, 4'(i), 3'd3, 2'd2, 16'h0055, 10'(i));
    seen = 0;
    for (int w = 0; w < 200 && !seen; w++) begin
      if (cmd_valid && cmd_code == ACT && cmd_phase) seen = 1;
      else @(negedge clk);
    end
    chk("t6_act_ph1_seen", seen, 1);
    chk("t6_q_count_before", q_count, 5);
    #2;
    rst_n = 0;
    #1;
    chk("t6_cmd_valid_async", cmd_valid, 0);
    chk("t6_q_count_async", q_count, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    cmd_log.delete();
    @(negedge clk);
    push_req(2'd0, 4'd12, 3'd3, 2'd2, 16'h0055, 10'h005);
    wait_drain();
    chk("t6_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() >= 1) chk("t6_first_is_act", cmd_log[0].code, ACT);

    // Write
    do_reset();
    push_req(2'd1, 4'd9, 3'd0, 2'd3, 16'h1234, 10'h2AB);
    wait_drain();
    chk("t7_ncmd", cmd_log.size(), 2);
    if (cmd_log.size() >= 2) begin
      chk("t7_act_row", cmd_log[0].row, 16'h1234);
      chk("t7_wr", cmd_log[1].code, WR);
      chk("t7_wr_col", cmd_log[1].col, 10'h2AB);
      chk("t7_wr_bank", cmd_log[1].bank, 2'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
